// File: rtl/aes_round_sched.sv
// AES-128 round scheduler. It steps an external round datapath through rounds 0..NR,
// one round per clock, and holds the running state and the last finished block.
module aes_round_sched #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         key_valid,
    input  logic [127:0] in_data,
    input  logic [127:0] round_in,
    output logic         ready,
    output logic         busy,
    output logic [127:0] state_q,
    output logic [3:0]   round,
    output logic [1:0]   mode,
    output logic [127:0] out,
    output logic         done,
    output logic         abort
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [127:0] state_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] out_q, out_d;
    logic         done_q, done_d;
    logic         abort_q, abort_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            round_q <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
            out_q   <= out_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        round_d = round_q;
        out_d   = out_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                if (start && key_valid) begin
                    state_d = in_data;
                    round_d = '0;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                if (key_valid) begin
                    state_d = round_in;
                    if (round_q == LAST_ROUND) begin
                        out_d   = round_in;
                        done_d  = 1'b1;
                        round_d = '0;
                        fsm_d   = IDLE;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end else begin
                    // Key lost mid-block: drop it, keep state_q as it was.
                    abort_d = 1'b1;
                    round_d = '0;
                    fsm_d   = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_comb begin
        mode = 2'b00;
        if (fsm_q == RUN) begin
            if (round_q == LAST_ROUND) begin
                mode = 2'b10;
            end else if (round_q != 4'd0) begin
                mode = 2'b01;
            end
        end
    end

    assign ready = (fsm_q == IDLE) && key_valid;
    assign busy  = (fsm_q == RUN);
    assign round = round_q;
    assign out   = out_q;
    assign done  = done_q;
    assign abort = abort_q;

endmodule

// File: tb/tb_aes_round_sched.sv
// Bench for aes_round_sched with an additive stub datapath; expected ciphertexts are
// queued at each accept and checked when done pulses.
module tb_aes_round_sched;

    localparam int NR = 10;

    logic         clk;
    logic         rst;
    logic         start;
    logic         key_valid;
    logic [127:0] in_data;
    logic [127:0] round_in;
    logic         ready;
    logic         busy;
    logic [127:0] state_q;
    logic [3:0]   round;
    logic [1:0]   mode;
    logic [127:0] dut_out;
    logic         done;
    logic         abort;

    int checks   = 0;
    int failures = 0;
    logic [127:0] exp_q[$];
    logic [127:0] last_out = '0;

    aes_round_sched #(.NR(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_valid (key_valid),
        .in_data   (in_data),
        .round_in  (round_in),
        .ready     (ready),
        .busy      (busy),
        .state_q   (state_q),
        .round     (round),
        .mode      (mode),
        .out       (dut_out),
        .done      (done),
        .abort     (abort)
    );

    // Stub round datapath.
    assign round_in = state_q + 128'(round) + 128'd1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] model(input logic [127:0] pt);
        logic [127:0] s;
        s = pt;
        for (int r = 0; r <= NR; r++) s = s + 128'(r) + 128'd1;
        return s;
    endfunction

    // Scoreboard monitor: every done pops one expected block.
    always @(negedge clk) begin
        if (rst && done) begin
            checks++;
            if (abort) begin
                failures++;
                $display("FAIL done_abort_overlap: done=1 abort=1, required not both");
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done: out=%h with empty scoreboard", dut_out);
            end else begin
                logic [127:0] e;
                e = exp_q.pop_front();
                if (dut_out !== e) begin
                    failures++;
                    $display("FAIL sb_out: got %h required %h", dut_out, e);
                end else begin
                    $display("done: out=%h ok", dut_out);
                end
                last_out = e;
            end
        end
    end

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; key_valid = 1'b1; in_data = '0;
        #1;
        checks++;
        if ({state_q, dut_out, round, mode, busy, done, abort, ready} !==
            {128'd0, 128'd0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_vals: round=%0d mode=%b busy=%b done=%b abort=%b ready=%b state=%h out=%h",
                     round, mode, busy, done, abort, ready, state_q, dut_out);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        $display("reset: checked");
    endtask

    task automatic test_basic;
        logic [1:0] em;
        in_data = '0; start = 1'b1;
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_ready: got %b required 1", ready);
        end
        exp_q.push_back(model(in_data));
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i <= NR; i++) begin
            em = (i == 0) ? 2'b00 : (i == NR) ? 2'b10 : 2'b01;
            checks++;
            if (round !== 4'(i) || mode !== em || busy !== 1'b1 || done !== 1'b0 || ready !== 1'b0) begin
                failures++;
                $display("FAIL basic_round%0d: round=%0d mode=%b busy=%b done=%b ready=%b required round=%0d mode=%b busy=1 done=0 ready=0",
                         i, round, mode, busy, done, ready, i, em);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || dut_out !== 128'h42 || ready !== 1'b1 || busy !== 1'b0 || round !== 4'd0) begin
            failures++;
            $display("FAIL basic_done: done=%b out=%h ready=%b busy=%b round=%0d required done=1 out=42 ready=1 busy=0 round=0",
                     done, dut_out, ready, busy, round);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_pulse: done=%b required 0", done);
        end
        $display("basic: in=0 latency %0d", NR + 1);
    endtask

    task automatic test_wrap;
        in_data = '1; start = 1'b1;
        exp_q.push_back(model(in_data));
        @(negedge clk);
        start = 1'b0; in_data = '0;
        for (int c = 0; c < 20; c++) begin
            if (done) break;
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || dut_out !== 128'h41) begin
            failures++;
            $display("FAIL wrap_out: done=%b out=%h required done=1 out=41", done, dut_out);
        end
        @(negedge clk);
        $display("wrap: in=all-ones");
    endtask

    task automatic test_back_to_back;
        int n_done;
        int t_first;
        int t_second;
        n_done = 0; t_first = -1; t_second = -1;
        start = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (done) begin
                n_done++;
                if (t_first < 0) t_first = c; else if (t_second < 0) t_second = c;
            end
            in_data = {$urandom, $urandom, $urandom, $urandom};
            if (ready && start) exp_q.push_back(model(in_data));
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (n_done != 2 || (t_second - t_first) != NR + 2) begin
            failures++;
            $display("FAIL b2b_spacing: dones=%0d gap=%0d required dones=2 gap=%0d",
                     n_done, t_second - t_first, NR + 2);
        end
        for (int c = 0; c < 20; c++) begin
            if (done) break;
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_drain_timeout: done=%b required 1", done);
        end
        @(negedge clk);
        $display("back_to_back: dones in window=%0d", n_done);
    endtask

    task automatic test_keyvalid_gate;
        key_valid = 1'b0; start = 1'b1; in_data = 128'h1234;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL gate_idle%0d: ready=%b busy=%b done=%b required 0 0 0", c, ready, busy, done);
            end
        end
        key_valid = 1'b1;
        exp_q.push_back(model(in_data));
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || round !== 4'd0 || state_q !== 128'h1234) begin
            failures++;
            $display("FAIL gate_accept: busy=%b round=%0d state=%h required busy=1 round=0 state=1234",
                     busy, round, state_q);
        end
        for (int c = 0; c < 20; c++) begin
            if (done) break;
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL gate_timeout: done=%b required 1", done);
        end
        @(negedge clk);
        $display("keyvalid_gate: accepted after key_valid rose");
    endtask

    task automatic test_abort;
        logic [127:0] prev_out;
        logic [127:0] prev_state;
        prev_out = last_out;
        in_data = 128'h55; start = 1'b1;
        exp_q.push_back(model(in_data));
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        checks++;
        if (round !== 4'd4) begin
            failures++;
            $display("FAIL abort_round: round=%0d required 4", round);
        end
        prev_state = state_q;
        key_valid = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        checks++;
        if (abort !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || round !== 4'd0 ||
            dut_out !== prev_out || state_q !== prev_state) begin
            failures++;
            $display("FAIL abort_pulse: abort=%b done=%b busy=%b round=%0d out=%h state=%h required abort=1 done=0 busy=0 round=0 out=%h state=%h",
                     abort, done, busy, round, dut_out, state_q, prev_out, prev_state);
        end
        key_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (abort !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_single: abort=%b done=%b busy=%b required 0 0 0", abort, done, busy);
        end
        $display("abort: dropped at round 4");
    endtask

    task automatic test_midrun_reset;
        in_data = 128'h77; start = 1'b1;
        exp_q.push_back(model(in_data));
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) @(negedge clk);
        rst = 1'b0;
        void'(exp_q.pop_back());
        #1;
        checks++;
        if ({state_q, dut_out, round, mode, busy, done, abort, ready} !==
            {128'd0, 128'd0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL midrun_reset: round=%0d mode=%b busy=%b done=%b abort=%b ready=%b state=%h out=%h",
                     round, mode, busy, done, abort, ready, state_q, dut_out);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || abort !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL midrun_quiet%0d: done=%b abort=%b busy=%b required 0 0 0", c, done, abort, busy);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        in_data = '0; start = 1'b1;
        exp_q.push_back(model(in_data));
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (done) break;
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || dut_out !== 128'h42) begin
            failures++;
            $display("FAIL reset_fresh: done=%b out=%h required done=1 out=42", done, dut_out);
        end
        @(negedge clk);
        $display("midrun_reset: fresh block after release");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_back_to_back();
        test_keyvalid_gate();
        test_abort();
        test_midrun_reset();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: %0d entries required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_round_sched.md
# aes_round_sched

Round scheduler for the AES-128 encryption datapath. It accepts a 128-bit block once the expanded key is available and steps the external round datapath (SubBytes/ShiftRows/MixColumns plus round-key XOR) through rounds 0..NR, one round per clock. It drives the round index that selects the 128-bit slice of the 1408-bit expanded key, and the per-round mode. It holds the running state register and presents the finished block with a single-cycle `done` pulse.

## Interface
- `NR`, 10, number of full-cipher rounds; round index runs 0..NR (NR+1 round keys, 128 bits each).
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low; clears all registers immediately on assertion.
- `start`  in  1  level request to begin a block; qualified by `ready`.
- `key_valid`  in  1  expanded key is stable and valid; must remain high for the whole operation.
- `in_data`  in  128  plaintext; sampled on the accept edge only.
- `round_in`  in  128  combinational result of the datapath for (`state_q`, `round`, `mode`).
- `ready`  out  1  `= (FSM==IDLE) & key_valid`.
- `busy`  out  1  high while FSM==RUN.
- `state_q`  out  128  running state register, fed to the datapath.
- `round`  out  4  current round index, used as key-slice select (`round*128`).
- `mode`  out  2  2'b00 key-XOR only (round 0); 2'b01 full round (1..NR-1); 2'b10 final round, no MixColumns (round NR); 2'b11 unused, never driven.
- `out`  out  128  last completed ciphertext; held until the next completion.
- `done`  out  1  one-cycle pulse when `out` updates.
- `abort`  out  1  one-cycle pulse when a block is dropped due to loss of `key_valid`.

## Operation
- FSM states: IDLE, RUN.
- IDLE: `busy`=0, `round`=0. On an edge with `start & key_valid`, the block loads `state_q <= in_data`, sets `round <= 0`, and moves to RUN. If `start` is high while `key_valid` is low, the request is ignored with no latching; the requester keeps `start` high.
- RUN, each edge with `key_valid`=1:
  - `state_q <= round_in`.
  - If `round == NR`: `out <= round_in`, `done <= 1`, `round <= 0`, move to IDLE.
  - Otherwise: `round <= round + 1`.
- `mode` is combinational from `round` while in RUN: 0 gives 2'b00, NR gives 2'b10, any other value gives 2'b01. In IDLE `mode` = 2'b00.
- RUN with `key_valid`=0 on an edge: drop the block, `abort <= 1`, `round <= 0`, move to IDLE. `out` and `done` are untouched; `state_q` keeps its last value.
- `start` during RUN is ignored; there is no queuing.
- `round` never exceeds NR. The counter is 4 bits, so NR ≤ 15.

## Timing
- Reset values: `state_q`=0, `out`=0, `round`=0, `mode`=2'b00, `busy`=0, `done`=0, `abort`=0, `ready`=`key_valid` (FSM=IDLE).
- Accept edge E0. RUN occupies the cycles after edges E0..E(NR); round r is evaluated in the cycle after edge Er.
- `done` is high for exactly one cycle after edge E(NR+1), with `out` valid in the same cycle. Latency from accept edge to `done` is NR+1 cycles (11 for NR=10).
- `ready` returns high in the same cycle as `done`. A `start` held high is accepted on the next edge (E(NR+2)), giving back-to-back throughput of one block per NR+2 cycles.
- `done` and `abort` are registered single-cycle pulses and are never high together.
- Asserting `rst` mid-RUN returns the block to its reset values immediately. No `done` or `abort` is produced.

## Test plan
- Stub datapath `round_in = state_q + round + 1` (128-bit add). Apply `key_valid`=1, `in_data`=0, pulse `start` -> `round` steps 0..10 with `mode` 00,01×9,10; `done` 11 cycles after accept; `out` = 128'h42.
- Same stub, `in_data`=128'hFFFF…FFFF -> `out` = 128'h41 (wraps modulo 2^128).
- `start` held high for 30 cycles -> two completions, `done` pulses 12 cycles apart; `in_data` is sampled only on the accept edges.
- `start`=1 with `key_valid`=0 for 5 cycles, then `key_valid`=1 -> no activity and `ready`=0 for the first 5 cycles; accept on the first edge with `key_valid`=1.
- `key_valid` dropped during round 4 -> `abort` pulses once, FSM returns to IDLE, `done` stays 0, `out` keeps its previous value.
- `rst` low during round 6 -> all outputs immediately at reset values; after release, a fresh block with `in_data`=0 completes with `out` = 128'h42.
